// File: rtl/reg_dump_reader_if.sv
// Debug read-out bus of reg_dump_reader: core stall handshake, regfile read-port
// takeover and the valid/ready word stream toward the debug sink.
interface reg_dump_reader_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 4
);
  logic             stall_req;
  logic             stall_ack;
  logic             dbg_sel;
  logic [IDXW-1:0]  dbg_srcA;
  logic [IDXW-1:0]  dbg_srcB;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_idx;

  modport master (
    output stall_req, dbg_sel, dbg_srcA, dbg_srcB, out_valid, out_data, out_idx,
    input  stall_ack, valA, valB, out_ready
  );

  modport slave (
    input  stall_req, dbg_sel, dbg_srcA, dbg_srcB, out_valid, out_data, out_idx,
    output stall_ack, valA, valB, out_ready
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Y86 register-file dump engine: stalls the core, reads registers in even/odd
// pairs through the regfile read ports and streams them out with a running sum.
module reg_dump_reader #(
  parameter int REGNUM = 8,
  parameter int WIDTH  = 32,
  parameter int IDXW   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  reg_dump_reader_if.master       bus,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        dump_sum
);

  localparam int NPAIR = REGNUM / 2;
  localparam int KW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam logic [IDXW-1:0] RNONE = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_READ, S_SEND0, S_SEND1, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] hold_a, hold_b, sum_r;
  logic [IDXW-1:0]  idx_even, idx_odd;
  logic             xfer, last_pair;

  function automatic logic [WIDTH-1:0] wrap_add3(input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    return acc + a + b;
  endfunction

  assign idx_even  = IDXW'({k, 1'b0});
  assign idx_odd   = idx_even | IDXW'(1);
  assign last_pair = (k == KW'(NPAIR - 1));
  assign xfer      = bus.out_valid && bus.out_ready;
  assign dump_sum  = sum_r;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   if (bus.stall_ack) state_nxt = S_READ;
      S_READ:  state_nxt = S_SEND0;
      S_SEND0: if (xfer) state_nxt = S_SEND1;
      S_SEND1: if (xfer) state_nxt = last_pair ? S_DONE : S_READ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pair counter, captured pair and running sum; the sum folds both ports in
  // on the READ edge so it is already final when DONE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      k      <= '0;
      hold_a <= '0;
      hold_b <= '0;
      sum_r  <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          k     <= '0;
          sum_r <= '0;
        end
        S_READ: begin
          hold_a <= bus.valA;
          hold_b <= bus.valB;
          sum_r  <= wrap_add3(sum_r, bus.valA, bus.valB);
        end
        S_SEND1: if (xfer && !last_pair) k <= k + KW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.stall_req = 1'b0;
    bus.dbg_sel   = 1'b0;
    bus.dbg_srcA  = RNONE;
    bus.dbg_srcB  = RNONE;
    bus.out_valid = 1'b0;
    bus.out_data  = hold_a;
    bus.out_idx   = RNONE;
    busy          = (state != S_IDLE);
    done          = 1'b0;
    unique case (state)
      S_REQ:   bus.stall_req = 1'b1;
      S_READ: begin
        bus.stall_req = 1'b1;
        bus.dbg_sel   = 1'b1;
        bus.dbg_srcA  = idx_even;
        bus.dbg_srcB  = idx_odd;
      end
      S_SEND0: begin
        bus.stall_req = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_idx   = idx_even;
      end
      S_SEND1: begin
        bus.stall_req = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = hold_b;
        bus.out_idx   = idx_odd;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural regfile and word logger.
module tb_reg_dump_reader;
  localparam int REGNUM = 8;
  localparam int WIDTH  = 32;
  localparam int IDXW   = 4;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic [WIDTH-1:0] dump_sum;

  always #5 clk = ~clk;

  reg_dump_reader_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  reg_dump_reader #(.REGNUM(REGNUM), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .dump_sum (dump_sum)
  );

  logic [WIDTH-1:0] regs [0:15];
  assign bus.valA = regs[bus.dbg_srcA];
  assign bus.valB = regs[bus.dbg_srcB];

  logic [WIDTH-1:0] got_data [$];
  logic [IDXW-1:0]  got_idx  [$];
  int               done_cnt;
  int               checks, passes;

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      got_data.push_back(bus.out_data);
      got_idx.push_back(bus.out_idx);
    end
    if (done) done_cnt++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    got_data.delete();
    got_idx.delete();
    done_cnt = 0;
  endtask

  task automatic load_default();
    for (int i = 0; i < 16; i++) regs[i] = '0;
    regs[0] = 32'h01234567; regs[1] = 32'h23456789;
    regs[2] = 32'h3456789A; regs[3] = 32'h456789AB;
    regs[4] = 32'h56789ABC; regs[5] = 32'h6789ABCD;
    regs[6] = 32'h789ABCDE; regs[7] = 32'h89ABCDEF;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_word(input logic [IDXW-1:0] idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid && bus.out_idx == idx) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.stall_ack = 1'b0; bus.out_ready = 1'b0;
    step(2);
    rst = 1'b0;
    checks++;
    if ({bus.stall_req, bus.dbg_sel, bus.out_valid, busy, done} !== 5'b0)
      $display("FAIL reset_ctrl: stall/sel/valid/busy/done=%b required 00000",
               {bus.stall_req, bus.dbg_sel, bus.out_valid, busy, done});
    else passes++;
    checks++;
    if ({bus.dbg_srcA, bus.dbg_srcB, bus.out_idx} !== 12'hFFF)
      $display("FAIL reset_idx: srcA/srcB/idx=%h required fff",
               {bus.dbg_srcA, bus.dbg_srcB, bus.out_idx});
    else passes++;
    checks++;
    if (bus.out_data !== 32'h0 || dump_sum !== 32'h0)
      $display("FAIL reset_data: out_data=%h dump_sum=%h required 0/0", bus.out_data, dump_sum);
    else passes++;
  endtask

  task automatic test_basic();
    bit ok, ok_w;
    load_default();
    bus.stall_ack = 1'b1; bus.out_ready = 1'b1;
    clear_log();
    pulse_start();
    checks++;
    if (bus.stall_req !== 1'b1 || busy !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL basic_req: stall_req=%b busy=%b valid=%b required 1 1 0",
               bus.stall_req, busy, bus.out_valid);
    else passes++;
    step();
    checks++;
    if (bus.dbg_sel !== 1'b1 || bus.dbg_srcA !== 4'h0 || bus.dbg_srcB !== 4'h1 || bus.out_valid !== 1'b0)
      $display("FAIL basic_read: sel=%b srcA=%h srcB=%h valid=%b required 1 0 1 0",
               bus.dbg_sel, bus.dbg_srcA, bus.dbg_srcB, bus.out_valid);
    else passes++;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h01234567 || bus.out_idx !== 4'h0)
      $display("FAIL basic_first: valid=%b data=%h idx=%h required 1 01234567 0",
               bus.out_valid, bus.out_data, bus.out_idx);
    else passes++;
    wait_done(100, ok);
    ok_w = (got_data.size() == 8);
    for (int i = 0; i < 8 && ok_w; i++)
      if (got_data[i] !== regs[i] || got_idx[i] !== 4'(i)) ok_w = 1'b0;
    checks++;
    if (!ok || !ok_w)
      $display("FAIL basic_words: done_seen=%0d words=%0d required done and 8 words R0..R7", ok, got_data.size());
    else passes++;
    checks++;
    if (dump_sum !== 32'h5E6F808B || done_cnt != 1)
      $display("FAIL basic_sum: dump_sum=%h done_pulses=%0d required 5e6f808b 1", dump_sum, done_cnt);
    else passes++;
    checks++;
    if (busy !== 1'b0 || bus.stall_req !== 1'b0 || done !== 1'b0)
      $display("FAIL basic_end: busy=%b stall_req=%b done=%b required 0 0 0", busy, bus.stall_req, done);
    else passes++;
  endtask

  task automatic test_backpressure();
    bit ok, ok_w, stable;
    load_default();
    bus.stall_ack = 1'b1; bus.out_ready = 1'b1;
    clear_log();
    pulse_start();
    wait_word(4'h2, ok);
    bus.out_ready = 1'b0;
    stable = ok;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3456789A || bus.out_idx !== 4'h2) stable = 1'b0;
    end
    checks++;
    if (!stable)
      $display("FAIL hold_stable: valid=%b data=%h idx=%h required 1 3456789a 2",
               bus.out_valid, bus.out_data, bus.out_idx);
    else passes++;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.out_ready = 1'b1;
    ok_w = (got_data.size() == 8);
    for (int i = 0; i < 8 && ok_w; i++)
      if (got_data[i] !== regs[i] || got_idx[i] !== 4'(i)) ok_w = 1'b0;
    checks++;
    if (!ok || !ok_w)
      $display("FAIL bp_words: done_seen=%0d words=%0d required done and 8 words R0..R7", ok, got_data.size());
    else passes++;
    checks++;
    if (dump_sum !== 32'h5E6F808B)
      $display("FAIL bp_sum: dump_sum=%h required 5e6f808b", dump_sum);
    else passes++;
  endtask

  task automatic test_stall_wait();
    bit ok, ok_w, held;
    load_default();
    bus.stall_ack = 1'b0; bus.out_ready = 1'b1;
    clear_log();
    pulse_start();
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.stall_req !== 1'b1 || bus.dbg_sel !== 1'b0 || bus.dbg_srcA !== 4'hF ||
          bus.dbg_srcB !== 4'hF || bus.out_valid !== 1'b0 || busy !== 1'b1) held = 1'b0;
      step();
    end
    checks++;
    if (!held)
      $display("FAIL req_hold: stall_req=%b sel=%b srcA=%h srcB=%h valid=%b required 1 0 f f 0",
               bus.stall_req, bus.dbg_sel, bus.dbg_srcA, bus.dbg_srcB, bus.out_valid);
    else passes++;
    bus.stall_ack = 1'b1;
    wait_done(100, ok);
    ok_w = (got_data.size() == 8);
    for (int i = 0; i < 8 && ok_w; i++)
      if (got_data[i] !== regs[i] || got_idx[i] !== 4'(i)) ok_w = 1'b0;
    checks++;
    if (!ok || !ok_w || dump_sum !== 32'h5E6F808B)
      $display("FAIL ack_late_dump: done_seen=%0d words=%0d sum=%h required done 8 5e6f808b",
               ok, got_data.size(), dump_sum);
    else passes++;
  endtask

  task automatic test_start_while_busy();
    bit ok, okw, ok_w;
    load_default();
    bus.stall_ack = 1'b1; bus.out_ready = 1'b1;
    clear_log();
    pulse_start();
    wait_word(4'h5, okw);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100, ok);
    step(10);
    ok_w = (got_data.size() == 8);
    for (int i = 0; i < 8 && ok_w; i++)
      if (got_data[i] !== regs[i] || got_idx[i] !== 4'(i)) ok_w = 1'b0;
    checks++;
    if (!okw || !ok || !ok_w || done_cnt != 1 || busy !== 1'b0)
      $display("FAIL start_busy: words=%0d done_pulses=%0d busy=%b required 8 1 0",
               got_data.size(), done_cnt, busy);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit ok, okw, ok_w;
    load_default();
    bus.stall_ack = 1'b1; bus.out_ready = 1'b1;
    clear_log();
    pulse_start();
    wait_word(4'h4, okw);
    rst = 1'b1;
    step();
    checks++;
    if (!okw || {bus.out_valid, bus.stall_req, busy, bus.dbg_sel} !== 4'b0 ||
        {bus.dbg_srcA, bus.dbg_srcB, bus.out_idx} !== 12'hFFF)
      $display("FAIL rst_mid: valid/stall/busy/sel=%b idx=%h required 0000 fff",
               {bus.out_valid, bus.stall_req, busy, bus.dbg_sel},
               {bus.dbg_srcA, bus.dbg_srcB, bus.out_idx});
    else passes++;
    rst = 1'b0;
    step();
    clear_log();
    pulse_start();
    wait_done(100, ok);
    ok_w = (got_data.size() == 8);
    for (int i = 0; i < 8 && ok_w; i++)
      if (got_data[i] !== regs[i] || got_idx[i] !== 4'(i)) ok_w = 1'b0;
    checks++;
    if (!ok || !ok_w || dump_sum !== 32'h5E6F808B)
      $display("FAIL rst_redump: done_seen=%0d words=%0d sum=%h required done 8 5e6f808b",
               ok, got_data.size(), dump_sum);
    else passes++;
  endtask

  task automatic test_overflow();
    bit ok;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    for (int i = 0; i < 8; i++) regs[i] = 32'hFFFFFFFF;
    bus.stall_ack = 1'b1; bus.out_ready = 1'b1;
    clear_log();
    pulse_start();
    wait_done(100, ok);
    checks++;
    if (!ok || dump_sum !== 32'hFFFFFFF8 || got_data.size() != 8)
      $display("FAIL overflow_sum: done_seen=%0d sum=%h words=%0d required done fffffff8 8",
               ok, dump_sum, got_data.size());
    else passes++;
    step(3);
    checks++;
    if (dump_sum !== 32'hFFFFFFF8)
      $display("FAIL sum_hold: dump_sum=%h required fffffff8", dump_sum);
    else passes++;
  endtask

  initial begin
    checks = 0; passes = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0;
    bus.stall_ack = 1'b0; bus.out_ready = 1'b0;
    load_default();
    test_reset();
    test_basic();
    test_backpressure();
    test_stall_wait();
    test_start_while_busy();
    test_reset_mid();
    test_overflow();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
